dma_ring_scheduler: RTL and testbench
=====================================

Name: dma_ring_scheduler

Overview:
Sequences simple_dma so that sensor line data streams into a ring of equal-size SDRAM buffers. Software no longer writes one DMA command per line. The block issues START/START_ADR/BUF_SIZE commands automatically and tracks completions through DONE_CNT. It honours software buffer releases and stops when the ring is full (cyclic mode) or after N buffers (one-shot mode). It sits in the CLK_80 bus domain between the Linux control registers and simple_dma.

Parameters:
ADR_W, 28, SDRAM word-address width (16-byte words)
CNT_W, 16, width of the DMA done counter and of all buffer counters
CMD_SLOTS, 1, maximum commands outstanding inside simple_dma (issued but not done)

Ports:
CLK  in  1  bus clock; all logic on its rising edge
SRST  in  1  synchronous reset, active-high
ENABLE  in  1  level; rising edge in IDLE latches config and starts; low stops issuing
MODE_CYCLIC  in  1  1 = endless ring, 0 = stop after NUM_BUFS buffers
RING_BASE  in  ADR_W  first buffer address
BUF_SIZE  in  ADR_W  buffer length in 16-byte words
NUM_SLOTS  in  CNT_W  number of buffers in the ring
NUM_BUFS  in  CNT_W  total buffers in one-shot mode
REL_VALID  in  1  software release strobe
REL_CNT  in  CNT_W  number of buffers released by software with REL_VALID
DMA_START  out  1  one-cycle command pulse to simple_dma
DMA_START_ADR  out  ADR_W  command address, valid while DMA_START is high
DMA_BUF_SIZE  out  ADR_W  command length
DMA_DONE_CNT  in  CNT_W  free-running done counter from simple_dma
FILLED  out  CNT_W  buffers done but not yet released
WR_SLOT  out  CNT_W  slot index of the next command
BUF_READY  out  1  one-cycle pulse when DMA_DONE_CNT advances
BUSY  out  1  high in every state except IDLE
FINISHED  out  1  sticky; set on one-shot completion, cleared on start
CFG_ERR  out  1  sticky; set on a rejected start, cleared on the next accepted start
REL_ERR  out  1  sticky; set on an over-release, cleared on start

Behaviour:
- Reset values: all outputs 0, state IDLE. The reset sample of DMA_DONE_CNT is stored as done_prev.
- Counters: issued, done and released are CNT_W-bit and wrap.
- Completion delta = DMA_DONE_CNT - done_prev (mod 2^CNT_W), computed every cycle.
  - done is incremented by the delta; a delta greater than 1 in one cycle is legal.
  - BUF_READY is high for one cycle when the delta is non-zero.
- Derived quantities:
  - outstanding = issued - done
  - FILLED = done - released
  - occupancy = issued - released
- Release handling:
  - REL_VALID adds REL_CNT to released.
  - If REL_CNT > FILLED, released advances by FILLED only and REL_ERR is set.
- State IDLE:
  - On an ENABLE rising edge, latch RING_BASE, BUF_SIZE, NUM_SLOTS, NUM_BUFS and MODE_CYCLIC.
  - If BUF_SIZE==0, NUM_SLOTS==0, or (MODE_CYCLIC==0 and NUM_BUFS==0): set CFG_ERR and stay in IDLE.
  - Otherwise: clear issued, done, released, WR_SLOT, FINISHED, CFG_ERR and REL_ERR; set done_prev to DMA_DONE_CNT; go to ISSUE.
- State ISSUE: a command may issue when all of these hold:
  - outstanding < CMD_SLOTS
  - occupancy < NUM_SLOTS
  - MODE_CYCLIC, or issued < NUM_BUFS
  - When it issues: DMA_START=1 for one cycle with DMA_START_ADR = slot_adr and DMA_BUF_SIZE = latched BUF_SIZE; issued increments; go to GAP.
- Slot addressing:
  - slot_adr is kept incrementally: += BUF_SIZE per issued command.
  - When WR_SLOT == NUM_SLOTS-1, WR_SLOT returns to 0 and slot_adr to RING_BASE. No multiplier is used.
- State GAP: one idle cycle, because simple_dma needs START low between commands; then go to ISSUE.
- One-shot completion: in ISSUE with MODE_CYCLIC==0 and issued==NUM_BUFS, go to DRAIN.
- ENABLE low: in ISSUE or GAP, go to DRAIN. A START pulse already emitted counts as issued.
- State DRAIN:
  - No new commands.
  - When outstanding==0: go to IDLE; set FINISHED if the run was one-shot and completed.
- SRST takes priority over everything.
  - Mid-operation it drops the current command and returns to IDLE; it must be asserted together with simple_dma's SRST.
- Latency: an ENABLE rise produces DMA_START 2 cycles later (IDLE→ISSUE, then the pulse).
- Simultaneous events in one cycle:
  - A done delta and a release in the same cycle are both applied.
  - REL_ERR is judged against FILLED including that cycle's delta.

Decomposition:
- Package dma_sched_pkg:
  - state enum (IDLE, ISSUE, GAP, DRAIN)
  - ADR_W and CNT_W defaults
  - helper function wrap_sub(a, b) for CNT_W modular difference
- One natural sub-module: ring_addr_gen, holding slot_adr and WR_SLOT, with wrap on NUM_SLOTS, load on start and advance on issue.

Test Plan:
1. One-shot run: RING_BASE=0, BUF_SIZE=972, NUM_SLOTS=8, NUM_BUFS=4, CMD_SLOTS=1, DMA model bumps done 100 cycles after START.
   - Required: four START pulses at addresses 0, 972, 1944, 2916, each after the previous done.
   - Then FINISHED=1, BUSY=0.
2. Cyclic ring-full stall: NUM_SLOTS=3, no releases.
   - Required: exactly 3 STARTs, at addresses 0, 972, 1944; FILLED=3; no further STARTs.
   - Then REL_VALID with REL_CNT=1: the next START goes to address 0 with WR_SLOT wrapped to 0.
3. Multi-step done: the model raises DMA_DONE_CNT by 2 in one cycle, starting from reset value 0xFFFF.
   - Required: done counter wraps to 1; FILLED increases by 2; one BUF_READY pulse.
4. Over-release: FILLED=1, REL_CNT=5.
   - Required: FILLED=0, REL_ERR=1, no START beyond the ring limit.
5. Config errors and stop:
   - BUF_SIZE=0 → CFG_ERR=1, BUSY stays 0.
   - ENABLE dropped while one command is outstanding → no new START; IDLE only after that command's done.
6. Mid-run reset: SRST while in GAP → next cycle all outputs 0, state IDLE; the next ENABLE restarts at RING_BASE.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types, default widths and counter helpers for the DMA ring scheduler.
package dma_sched_pkg;
    localparam int ADR_W_DEF = 28;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_e;

    function automatic logic [CNT_W_DEF-1:0] wrap_sub(input logic [CNT_W_DEF-1:0] a,
                                                      input logic [CNT_W_DEF-1:0] b);
        return a - b;
    endfunction
endpackage

// File: rtl/dma_ring_scheduler_ring_addr_gen.sv
// ring_addr_gen: current slot index and slot address, stepped by BUF_SIZE and wrapped to the
// ring base after the last slot so no multiplier is needed.
module ring_addr_gen
    import dma_sched_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [ADR_W-1:0] load_adr_i,
    input  logic [ADR_W-1:0] base_i,
    input  logic [ADR_W-1:0] size_i,
    input  logic [CNT_W-1:0] nslots_i,
    output logic [ADR_W-1:0] slot_adr_o,
    output logic [CNT_W-1:0] wr_slot_o
);
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic             last;

    always_comb begin
        last   = slot_q == nslots_i - CNT_W'(1);
        adr_d  = load_i ? load_adr_i : adv_i ? (last ? base_i : adr_q + size_i) : adr_q;
        slot_d = load_i ? '0 : adv_i ? (last ? '0 : slot_q + CNT_W'(1)) : slot_q;
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            adr_q  <= '0;
            slot_q <= '0;
        end else begin
            adr_q  <= adr_d;
            slot_q <= slot_d;
        end
    end

    assign slot_adr_o = adr_q;
    assign wr_slot_o  = slot_q;
endmodule

// File: rtl/dma_ring_scheduler.sv
// dma_ring_scheduler: issues simple_dma commands into a ring of equal-size buffers, tracking
// completions from the free-running done counter and software releases.
module dma_ring_scheduler
    import dma_sched_pkg::*;
#(
    parameter int ADR_W     = ADR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int CMD_SLOTS = 1
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             ENABLE,
    input  logic             MODE_CYCLIC,
    input  logic [ADR_W-1:0] RING_BASE,
    input  logic [ADR_W-1:0] BUF_SIZE,
    input  logic [CNT_W-1:0] NUM_SLOTS,
    input  logic [CNT_W-1:0] NUM_BUFS,
    input  logic             REL_VALID,
    input  logic [CNT_W-1:0] REL_CNT,
    output logic             DMA_START,
    output logic [ADR_W-1:0] DMA_START_ADR,
    output logic [ADR_W-1:0] DMA_BUF_SIZE,
    input  logic [CNT_W-1:0] DMA_DONE_CNT,
    output logic [CNT_W-1:0] FILLED,
    output logic [CNT_W-1:0] WR_SLOT,
    output logic             BUF_READY,
    output logic             BUSY,
    output logic             FINISHED,
    output logic             CFG_ERR,
    output logic             REL_ERR
);
    localparam logic [CNT_W-1:0] SLOTS = CNT_W'(CMD_SLOTS);

    state_e           state_q, state_d;
    logic             en_q, cyclic_q, cyclic_d, start_q, start_d, rdy_q;
    logic             fin_q, fin_d, cfg_err_q, cfg_err_d, rel_err_q, rel_err_d;
    logic [ADR_W-1:0] base_q, base_d, size_q, size_d, start_adr_q, start_adr_d, slot_adr;
    logic [CNT_W-1:0] nslots_q, nslots_d, nbufs_q, nbufs_d, prev_q;
    logic [CNT_W-1:0] issued_q, issued_d, done_q, done_d, rel_q, rel_d;
    logic [CNT_W-1:0] delta, done_now, filled_now, outstanding, occupancy;
    logic             over_rel, can_issue, one_shot_done, cfg_bad, load, adv;

    always_comb begin
        delta         = wrap_sub(DMA_DONE_CNT, prev_q);
        done_now      = done_q + delta;
        filled_now    = wrap_sub(done_now, rel_q);
        over_rel      = REL_VALID && REL_CNT > filled_now;
        outstanding   = wrap_sub(issued_q, done_q);
        occupancy     = wrap_sub(issued_q, rel_q);
        one_shot_done = !cyclic_q && issued_q == nbufs_q;
        can_issue     = outstanding < SLOTS && occupancy < nslots_q && (cyclic_q || issued_q < nbufs_q);
        cfg_bad       = BUF_SIZE == '0 || NUM_SLOTS == '0 || (!MODE_CYCLIC && NUM_BUFS == '0);
        state_d       = state_q;
        start_d       = 1'b0;
        issued_d      = issued_q;
        done_d        = done_now;
        // An over-release is clamped to what is actually filled this cycle.
        rel_d         = rel_q + (REL_VALID ? (over_rel ? filled_now : REL_CNT) : '0);
        rel_err_d     = rel_err_q | over_rel;
        fin_d         = fin_q;
        cfg_err_d     = cfg_err_q;
        cyclic_d      = cyclic_q;
        base_d        = base_q;
        size_d        = size_q;
        nslots_d      = nslots_q;
        nbufs_d       = nbufs_q;
        load          = 1'b0;
        adv           = 1'b0;
        case (state_q)
            IDLE: if (ENABLE && !en_q) begin
                cyclic_d = MODE_CYCLIC;
                base_d   = RING_BASE;
                size_d   = BUF_SIZE;
                nslots_d = NUM_SLOTS;
                nbufs_d  = NUM_BUFS;
                if (cfg_bad) cfg_err_d = 1'b1;
                else begin
                    issued_d  = '0;
                    done_d    = '0;
                    rel_d     = '0;
                    fin_d     = 1'b0;
                    cfg_err_d = 1'b0;
                    rel_err_d = 1'b0;
                    load      = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: if (!ENABLE || one_shot_done) state_d = DRAIN;
                else if (can_issue) begin
                    start_d  = 1'b1;
                    issued_d = issued_q + CNT_W'(1);
                    adv      = 1'b1;
                    state_d  = GAP;
                end
            GAP: state_d = ENABLE ? ISSUE : DRAIN;
            DRAIN: if (outstanding == '0) begin
                state_d = IDLE;
                fin_d   = fin_q | one_shot_done;
            end
            default: state_d = IDLE;
        endcase
        start_adr_d = start_d ? slot_adr : start_adr_q;
    end

    always_ff @(posedge CLK) begin
        prev_q <= DMA_DONE_CNT;
        if (SRST) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            cyclic_q    <= 1'b0;
            start_q     <= 1'b0;
            rdy_q       <= 1'b0;
            fin_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            rel_err_q   <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            start_adr_q <= '0;
            nslots_q    <= '0;
            nbufs_q     <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            rel_q       <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= ENABLE;
            cyclic_q    <= cyclic_d;
            start_q     <= start_d;
            rdy_q       <= delta != '0;
            fin_q       <= fin_d;
            cfg_err_q   <= cfg_err_d;
            rel_err_q   <= rel_err_d;
            base_q      <= base_d;
            size_q      <= size_d;
            start_adr_q <= start_adr_d;
            nslots_q    <= nslots_d;
            nbufs_q     <= nbufs_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            rel_q       <= rel_d;
        end
    end

    ring_addr_gen #(.ADR_W(ADR_W), .CNT_W(CNT_W)) u_addr (
        .CLK       (CLK),
        .SRST      (SRST),
        .load_i    (load),
        .adv_i     (adv),
        .load_adr_i(RING_BASE),
        .base_i    (base_q),
        .size_i    (size_q),
        .nslots_i  (nslots_q),
        .slot_adr_o(slot_adr),
        .wr_slot_o (WR_SLOT)
    );

    assign DMA_START     = start_q;
    assign DMA_START_ADR = start_adr_q;
    assign DMA_BUF_SIZE  = size_q;
    assign FILLED        = wrap_sub(done_q, rel_q);
    assign BUF_READY     = rdy_q;
    assign BUSY          = state_q != IDLE;
    assign FINISHED      = fin_q;
    assign CFG_ERR       = cfg_err_q;
    assign REL_ERR       = rel_err_q;
endmodule

// File: tb/tb_dma_ring_scheduler.sv
// tb_dma_ring_scheduler: directed test of the DMA ring scheduler with a simple_dma done-counter model.
module tb_dma_ring_scheduler;
    localparam int ADR_W = 28;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             srst, enable, cyclic, rel_valid;
    logic [ADR_W-1:0] ring_base, buf_size;
    logic [CNT_W-1:0] num_slots, num_bufs, rel_cnt, done_cnt;
    logic             dma_start, buf_ready, busy, finished, cfg_err, rel_err;
    logic [ADR_W-1:0] start_adr, dma_size;
    logic [CNT_W-1:0] filled, wr_slot;

    int checks = 0, failures = 0;
    int start_cnt, timer, lat, overlap, n;
    logic [ADR_W-1:0] adrs [16];

    dma_ring_scheduler dut (
        .CLK(clk), .SRST(srst), .ENABLE(enable), .MODE_CYCLIC(cyclic),
        .RING_BASE(ring_base), .BUF_SIZE(buf_size), .NUM_SLOTS(num_slots), .NUM_BUFS(num_bufs),
        .REL_VALID(rel_valid), .REL_CNT(rel_cnt),
        .DMA_START(dma_start), .DMA_START_ADR(start_adr), .DMA_BUF_SIZE(dma_size),
        .DMA_DONE_CNT(done_cnt), .FILLED(filled), .WR_SLOT(wr_slot), .BUF_READY(buf_ready),
        .BUSY(busy), .FINISHED(finished), .CFG_ERR(cfg_err), .REL_ERR(rel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_start"}, 32'(dma_start), 0);
        chk({pfx, "_start_adr"}, 32'(start_adr), 0);
        chk({pfx, "_buf_size"}, 32'(dma_size), 0);
        chk({pfx, "_filled"}, 32'(filled), 0);
        chk({pfx, "_wr_slot"}, 32'(wr_slot), 0);
        chk({pfx, "_buf_ready"}, 32'(buf_ready), 0);
        chk({pfx, "_finished"}, 32'(finished), 0);
        chk({pfx, "_cfg_err"}, 32'(cfg_err), 0);
        chk({pfx, "_rel_err"}, 32'(rel_err), 0);
    endtask

    // One clock; samples outputs 1 time unit after the edge and runs the done-counter model.
    task automatic step();
        @(posedge clk);
        #1;
        if (dma_start) begin
            if (timer != 0) overlap++;
            if (start_cnt < 16) adrs[start_cnt] = start_adr;
            start_cnt++;
            timer = lat;
        end else if (timer > 0) begin
            timer--;
            if (timer == 0) done_cnt = done_cnt + 16'd1;
        end
    endtask

    initial begin
        srst = 1; enable = 0; cyclic = 0; rel_valid = 0; rel_cnt = 0;
        ring_base = 0; buf_size = 0; num_slots = 0; num_bufs = 0; done_cnt = 16'hFFFF;
        start_cnt = 0; timer = 0; lat = 100; overlap = 0;
        step(); step();
        chk_zero("reset");
        srst = 0;
        step();

        buf_size = 0; num_slots = 8; num_bufs = 4; enable = 1;
        step(); step();
        chk("cfg_err_set", 32'(cfg_err), 1);
        chk("cfg_err_busy", 32'(busy), 0);
        chk("cfg_err_nostart", start_cnt, 0);
        enable = 0;
        step();

        buf_size = 972; enable = 1;
        step();
        chk("lat_busy", 32'(busy), 1);
        chk("lat_start_c1", 32'(dma_start), 0);
        step();
        chk("lat_start_c2", 32'(dma_start), 1);
        chk("cfg_err_clr", 32'(cfg_err), 0);
        n = 0;
        while (busy && n < 2000) begin step(); n++; end
        chk("os_timeout", 32'(n < 2000), 1);
        chk("os_starts", start_cnt, 4);
        chk("os_adr0", 32'(adrs[0]), 0);
        chk("os_adr1", 32'(adrs[1]), 972);
        chk("os_adr2", 32'(adrs[2]), 1944);
        chk("os_adr3", 32'(adrs[3]), 2916);
        chk("os_overlap", overlap, 0);
        chk("os_finished", 32'(finished), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_filled", 32'(filled), 4);
        enable = 0;
        step();

        cyclic = 1; num_slots = 3; lat = 5; start_cnt = 0; enable = 1;
        repeat (100) step();
        chk("ring_starts", start_cnt, 3);
        chk("ring_adr0", 32'(adrs[0]), 0);
        chk("ring_adr1", 32'(adrs[1]), 972);
        chk("ring_adr2", 32'(adrs[2]), 1944);
        chk("ring_filled", 32'(filled), 3);
        chk("ring_wr_slot", 32'(wr_slot), 0);
        chk("ring_busy", 32'(busy), 1);
        chk("ring_fin_clr", 32'(finished), 0);
        rel_cnt = 1; rel_valid = 1;
        step();
        rel_valid = 0;
        chk("rel1_filled", 32'(filled), 2);
        n = 0;
        while (start_cnt < 4 && n < 50) begin step(); n++; end
        enable = 0;
        chk("wrap_timeout", 32'(n < 50), 1);
        chk("wrap_adr", 32'(adrs[3]), 0);
        chk("wrap_wr_slot", 32'(wr_slot), 1);

        step(); step();
        chk("stop_busy_pending", 32'(busy), 1);
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        chk("stop_timeout", 32'(n < 100), 1);
        chk("stop_after_done", timer, 0);
        chk("stop_no_start", start_cnt, 4);
        chk("stop_not_finished", 32'(finished), 0);
        chk("stop_filled", 32'(filled), 3);

        rel_cnt = 2; rel_valid = 1;
        step();
        chk("rel2_filled", 32'(filled), 1);
        chk("rel2_no_err", 32'(rel_err), 0);
        rel_cnt = 5;
        step();
        rel_valid = 0;
        chk("over_filled", 32'(filled), 0);
        chk("over_rel_err", 32'(rel_err), 1);
        chk("over_no_start", start_cnt, 4);

        done_cnt = 16'hFFFF; srst = 1;
        step(); step();
        srst = 0;
        chk("rst_rel_err_clr", 32'(rel_err), 0);
        done_cnt = 16'h0001;
        step();
        chk("multi_ready", 32'(buf_ready), 1);
        chk("multi_filled", 32'(filled), 2);
        step();
        chk("multi_ready_pulse", 32'(buf_ready), 0);
        chk("multi_filled_hold", 32'(filled), 2);

        ring_base = 100; buf_size = 10; num_slots = 4; lat = 3; start_cnt = 0; enable = 1;
        step();
        chk("mid_busy", 32'(busy), 1);
        step();
        chk("mid_start", 32'(dma_start), 1);
        chk("mid_adr", 32'(start_adr), 100);
        chk("mid_size", 32'(dma_size), 10);
        srst = 1; timer = 0;
        step();
        chk_zero("midrst");
        srst = 0; enable = 0; ring_base = 200;
        step();
        enable = 1;
        step(); step();
        chk("restart_start", 32'(dma_start), 1);
        chk("restart_adr", 32'(start_adr), 200);
        chk("restart_wr_slot", 32'(wr_slot), 1);
        enable = 0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
